// File: rtl/frame_streamer_if.sv
// Pixel-stream bundle for frame_streamer: host control, BRAM read port, and the valid/data pixel stream.
// The master modport is the streamer side; slave is the host/BRAM/consumer side.
interface frame_streamer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic                  i_start;
  logic                  i_pause;
  logic                  o_mem_en;
  logic [ADDR_WIDTH-1:0] o_mem_addr;
  logic [DATA_WIDTH-1:0] i_mem_data;
  logic                  o_valid;
  logic [DATA_WIDTH-1:0] o_data;
  logic                  o_sof;
  logic                  o_eol;
  logic                  o_eof;
  logic                  o_busy;
  logic                  o_done;

  modport master (
    input  i_start, i_pause, i_mem_data,
    output o_mem_en, o_mem_addr, o_valid, o_data, o_sof, o_eol, o_eof, o_busy, o_done
  );

  modport slave (
    output i_start, i_pause, i_mem_data,
    input  o_mem_en, o_mem_addr, o_valid, o_data, o_sof, o_eol, o_eof, o_busy, o_done
  );
endinterface

// File: rtl/frame_streamer.sv
// Raster-scan frame reader: streams an IMG_WIDTH x IMG_HEIGHT BRAM image row-major with sof/eol/eof markers.
// Read issue to o_valid is 2 cycles; no downstream backpressure, bubbles only while i_pause holds reads off.
module frame_streamer #(
  parameter int IMG_WIDTH  = 5,
  parameter int IMG_HEIGHT = 5,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
  input logic              clk,
  input logic              rst,
  frame_streamer_if.master bus
);
  localparam int NPIX  = IMG_WIDTH * IMG_HEIGHT;
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NPIX - 1);
  localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                state;
  state_t                state_nxt;
  logic                  mem_en;
  logic                  frame_start;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic                  rd_vld;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  sof_q;
  logic                  eol_q;
  logic                  eof_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    mem_en      = 1'b0;
    frame_start = 1'b0;
    case (state)
      IDLE: begin
        if (bus.i_start) begin
          state_nxt   = RUN;
          frame_start = 1'b1;
        end
      end
      RUN: begin
        if (!bus.i_pause) begin
          mem_en = 1'b1;
          if (rd_cnt == LAST_ADDR) state_nxt = DRAIN;
        end
      end
      // Only the final pixel carries eof, so its beat marks the end of the drain.
      DRAIN: begin
        if (valid_q && eof_q) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt  <= '0;
      rd_vld  <= 1'b0;
      col     <= '0;
      row     <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      rd_vld  <= mem_en;
      valid_q <= rd_vld;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      eof_q   <= 1'b0;

      // The counter parks on the last address so o_mem_addr never leaves the image.
      if (frame_start)                         rd_cnt <= '0;
      else if (mem_en && rd_cnt != LAST_ADDR) rd_cnt <= rd_cnt + 1'b1;

      if (frame_start) begin
        col <= '0;
        row <= '0;
      end else if (rd_vld) begin
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (rd_vld) begin
        data_q <= bus.i_mem_data;
        sof_q  <= (col == '0) && (row == '0);
        eol_q  <= (col == LAST_COL);
        eof_q  <= (col == LAST_COL) && (row == LAST_ROW);
      end
    end
  end

  assign bus.o_mem_en   = mem_en;
  assign bus.o_mem_addr = rd_cnt;
  assign bus.o_valid    = valid_q;
  assign bus.o_data     = data_q;
  assign bus.o_sof      = sof_q;
  assign bus.o_eol      = eol_q;
  assign bus.o_eof      = eof_q;
  assign bus.o_busy     = (state == RUN) || (state == DRAIN);
  assign bus.o_done     = (state == DONE);
endmodule

// File: doc/frame_streamer.md
# frame_streamer

Raster-scan pixel source that reads one IMG_WIDTH×IMG_HEIGHT frame from a single-port image BRAM and drives it as a valid/data stream into the line-buffer/window stage (`sliding_window`-style `i_valid`/`i_data` consumer).
- Provides the transmit end of the pixel-stream interface: one pixel per valid beat, row-major, no backpressure from downstream.
- Bubbles are inserted only by a host-controlled pause input.
- Emits frame/row markers and a done pulse for the control FSM.

## Interface
Parameters:
- IMG_WIDTH, 5, pixels per row (≥2)
- IMG_HEIGHT, 5, rows per frame (≥2)
- DATA_WIDTH, 8, pixel width in bits
- ADDR_WIDTH, $clog2(IMG_WIDTH*IMG_HEIGHT), BRAM address width

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- i_start  in  1  start one frame; sampled only in IDLE
- i_pause  in  1  while high in RUN, no new read is issued
- o_mem_en  out  1  BRAM read enable
- o_mem_addr  out  ADDR_WIDTH  BRAM read address (pixel index row*IMG_WIDTH+col)
- i_mem_data  in  DATA_WIDTH  BRAM read data, valid the cycle after o_mem_en
- o_valid  out  1  pixel beat valid
- o_data  out  DATA_WIDTH  pixel value
- o_sof  out  1  with o_valid: first pixel of frame
- o_eol  out  1  with o_valid: last pixel of a row
- o_eof  out  1  with o_valid: last pixel of frame
- o_busy  out  1  frame in progress
- o_done  out  1  one-cycle pulse after the last beat

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN on i_start. Read counter is cleared to 0.
- RUN:
  - Each cycle with i_pause=0: assert o_mem_en with o_mem_addr = read counter, then increment.
  - When address N−1 (N = IMG_WIDTH*IMG_HEIGHT) is issued, go to DRAIN.
  - With i_pause=1: o_mem_en=0 and the address holds.
- DRAIN: wait until the last in-flight pixel has been output, then go to DONE.
  - Reads already issued always complete; i_pause does not affect them.
- DONE: o_done=1 for one cycle, then → IDLE.
- Read pipeline:
  - o_mem_en is delayed one cycle to become an internal "data valid".
  - On that cycle, i_mem_data is registered into o_data, and o_valid is asserted the following cycle.
- Output column/row counters advance per output beat. They generate:
  - o_sof at col=0, row=0
  - o_eol at col=IMG_WIDTH−1
  - o_eof at the last pixel
- o_data holds its last value while o_valid=0.
- o_mem_addr holds its value when o_mem_en=0.
- i_start outside IDLE is ignored, including in the DONE cycle.
- o_busy=1 in RUN and DRAIN, 0 in IDLE and DONE.
- Reset values: o_valid, o_sof, o_eol, o_eof, o_busy, o_done, o_mem_en = 0; o_data = 0; o_mem_addr = 0; state IDLE; all counters 0.
- rst mid-frame: next cycle all outputs are at reset values and state is IDLE. In-flight reads are discarded and produce no o_valid.

## Timing
- Cycle 0: i_start sampled high.
- Cycle 1: state RUN, o_mem_en=1, addr 0.
- No pause: pixel k has o_valid in cycle 3+k. Read-issue to o_valid latency is 2 cycles.
- Last beat (o_eof) is at cycle N+2. o_busy is high for cycles 1..N+2. o_done is high at cycle N+3.
- Pause of P cycles during RUN delays every later beat by P cycles. It creates exactly P o_valid-low gaps, starting 2 cycles after the pause begins.
- Back-to-back frames: i_start asserted in the cycle o_done is high is ignored. i_start at cycle N+4 (state IDLE) is accepted.
- Sustained throughput is one pixel per cycle.

## Test plan
- Basic frame: 5×5 BRAM preloaded with 1..25, pulse i_start.
  - o_valid for 25 consecutive cycles (cycles 3..27) with o_data 1..25.
  - o_sof on 1; o_eol on 5, 10, 15, 20, 25; o_eof on 25.
  - o_done at cycle 28.
- Pause: same image, i_pause high for cycles 4–6.
  - Data 1..25 still in order, with exactly one 3-cycle o_valid gap between 3 and 4.
  - o_done delayed to cycle 31.
- Ignored start: pulse i_start again at cycle 10 and during the o_done cycle.
  - Only one frame of 25 beats is produced.
  - o_busy never glitches low between cycles 1 and 27.
- Reset mid-frame: assert rst at cycle 12.
  - From cycle 13, all outputs are 0 and no further o_valid appears.
  - A new i_start then yields a full 1..25 frame from addr 0.
- Non-square frame: IMG_WIDTH=4, IMG_HEIGHT=3, data 0xA0..0xAB.
  - 12 beats, with o_eol on 0xA3, 0xA7, 0xAB.
  - o_mem_addr sequence 0..11.
- Back-to-back: second i_start at first IDLE cycle after o_done.
  - Second frame's first o_valid exactly 3 cycles later, identical contents.
